// File: rtl/alu_rs_scheduler_pkg.sv
// alu_rs_scheduler_pkg: shared widths, op encodings and reservation-station entry layout
package alu_rs_scheduler_pkg;
  localparam int ROB_SIZE_BIT = 4;
  localparam int RS_TYPE_BIT = 5;
  localparam int RS_SIZE_BIT_DEF = 3;
  typedef enum logic [RS_TYPE_BIT-1:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  } alu_op_e;
  typedef struct packed {
    logic                    busy;
    logic [RS_TYPE_BIT-1:0]  op;
    logic [ROB_SIZE_BIT-1:0] rob_idx;
    logic [31:0]             vj;
    logic [31:0]             vk;
    logic                    qj_busy;
    logic [ROB_SIZE_BIT-1:0] qj;
    logic                    qk_busy;
    logic [ROB_SIZE_BIT-1:0] qk;
  } rs_entry_t;
endpackage

// File: rtl/alu_rs_scheduler_sel.sv
// rs_priority_select: valid flag plus index of the lowest set bit of a vector
module rs_priority_select #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    valid_o = |vec_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec_i[i]) idx_o = i[W-1:0];
  end
endmodule

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: ALU reservation station with CDB wakeup and lowest-index issue
module alu_rs_scheduler import alu_rs_scheduler_pkg::*; #(
  parameter int RS_SIZE_BIT = RS_SIZE_BIT_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear_in,
  input  logic                    dis_valid,
  input  logic [RS_TYPE_BIT-1:0]  dis_op,
  input  logic [ROB_SIZE_BIT-1:0] dis_rob_idx,
  input  logic [31:0]             dis_vj,
  input  logic [31:0]             dis_vk,
  input  logic                    dis_qj_busy,
  input  logic                    dis_qk_busy,
  input  logic [ROB_SIZE_BIT-1:0] dis_qj,
  input  logic [ROB_SIZE_BIT-1:0] dis_qk,
  input  logic                    cdb_alu_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_alu_rob_idx,
  input  logic [31:0]             cdb_alu_value,
  input  logic                    cdb_lsb_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_lsb_rob_idx,
  input  logic [31:0]             cdb_lsb_value,
  output logic                    full,
  output logic                    alu_valid,
  output logic [31:0]             alu_r1,
  output logic [31:0]             alu_r2,
  output logic [ROB_SIZE_BIT-1:0] alu_rob_idx,
  output logic [RS_TYPE_BIT-1:0]  alu_op
);
  localparam int N = 1 << RS_SIZE_BIT;
  rs_entry_t ent_q [N];
  rs_entry_t ent_d [N];
  logic [N-1:0] busy, ready;
  logic free_vld, rdy_vld;
  logic [RS_SIZE_BIT-1:0] free_idx, rdy_idx;
  logic alu_valid_d;
  logic [31:0] alu_r1_d, alu_r2_d;
  logic [ROB_SIZE_BIT-1:0] alu_rob_idx_d;
  logic [RS_TYPE_BIT-1:0] alu_op_d;
  // returns {still_pending, value}; the ALU bus wins when both buses carry the tag
  function automatic logic [32:0] snoop(input logic pend, input logic [ROB_SIZE_BIT-1:0] tag,
                                        input logic [31:0] v);
    return !pend ? {1'b0, v} :
           (cdb_alu_valid && cdb_alu_rob_idx == tag) ? {1'b0, cdb_alu_value} :
           (cdb_lsb_valid && cdb_lsb_rob_idx == tag) ? {1'b0, cdb_lsb_value} : {1'b1, v};
  endfunction
  always_comb
    for (int i = 0; i < N; i++) begin
      busy[i] = ent_q[i].busy;
      ready[i] = ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
    end
  assign full = &busy;
  rs_priority_select #(.N(N), .W(RS_SIZE_BIT)) u_free (
    .vec_i(~busy), .valid_o(free_vld), .idx_o(free_idx)
  );
  rs_priority_select #(.N(N), .W(RS_SIZE_BIT)) u_ready (
    .vec_i(ready), .valid_o(rdy_vld), .idx_o(rdy_idx)
  );
  always_comb begin
    ent_d = ent_q;
    alu_valid_d = 1'b0;
    alu_r1_d = alu_r1;
    alu_r2_d = alu_r2;
    alu_rob_idx_d = alu_rob_idx;
    alu_op_d = alu_op;
    for (int i = 0; i < N; i++)
      if (ent_q[i].busy) begin
        {ent_d[i].qj_busy, ent_d[i].vj} = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
        {ent_d[i].qk_busy, ent_d[i].vk} = snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
      end
    if (rdy_vld && !clear_in) begin
      ent_d[rdy_idx].busy = 1'b0;
      alu_valid_d = 1'b1;
      alu_r1_d = ent_q[rdy_idx].vj;
      alu_r2_d = ent_q[rdy_idx].vk;
      alu_rob_idx_d = ent_q[rdy_idx].rob_idx;
      alu_op_d = ent_q[rdy_idx].op;
    end
    // free slot comes from the pre-issue busy set, so it never collides with the issued slot
    if (dis_valid && free_vld) begin
      ent_d[free_idx].busy = 1'b1;
      ent_d[free_idx].op = dis_op;
      ent_d[free_idx].rob_idx = dis_rob_idx;
      ent_d[free_idx].qj = dis_qj;
      ent_d[free_idx].qk = dis_qk;
      {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} = snoop(dis_qj_busy, dis_qj, dis_vj);
      {ent_d[free_idx].qk_busy, ent_d[free_idx].vk} = snoop(dis_qk_busy, dis_qk, dis_vk);
    end
    if (clear_in)
      for (int i = 0; i < N; i++) ent_d[i].busy = 1'b0;
  end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      for (int i = 0; i < N; i++) ent_q[i] <= '0;
      alu_valid <= 1'b0;
      alu_r1 <= '0;
      alu_r2 <= '0;
      alu_rob_idx <= '0;
      alu_op <= '0;
    end else if (rdy_in) begin
      ent_q <= ent_d;
      alu_valid <= alu_valid_d;
      alu_r1 <= alu_r1_d;
      alu_r2 <= alu_r2_d;
      alu_rob_idx <= alu_rob_idx_d;
      alu_op <= alu_op_d;
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: directed scenarios plus random traffic against a slot-array model
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst, rdy, flush, dv, djb, dkb, cav, clv;
  logic [RS_TYPE_BIT-1:0] dop;
  logic [ROB_SIZE_BIT-1:0] drob, dqj, dqk, cat, clt;
  logic [31:0] dvj, dvk, caval, clval;
  logic full, av;
  logic [31:0] ar1, ar2;
  logic [ROB_SIZE_BIT-1:0] arob;
  logic [RS_TYPE_BIT-1:0] aop;
  int n_cmp = 0, n_err = 0;
  bit chk = 0;

  alu_rs_scheduler dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(flush),
    .dis_valid(dv), .dis_op(dop), .dis_rob_idx(drob), .dis_vj(dvj), .dis_vk(dvk),
    .dis_qj_busy(djb), .dis_qk_busy(dkb), .dis_qj(dqj), .dis_qk(dqk),
    .cdb_alu_valid(cav), .cdb_alu_rob_idx(cat), .cdb_alu_value(caval),
    .cdb_lsb_valid(clv), .cdb_lsb_rob_idx(clt), .cdb_lsb_value(clval),
    .full(full), .alu_valid(av), .alu_r1(ar1), .alu_r2(ar2), .alu_rob_idx(arob), .alu_op(aop)
  );
  always #5 clk = ~clk;

  // model: one record per slot, tags kept as plain ints
  bit m_busy [N], m_pj [N], m_pk [N];
  int m_op [N], m_rob [N], m_tj [N], m_tk [N];
  logic [31:0] m_vj [N], m_vk [N];
  bit m_av;
  logic [31:0] m_r1, m_r2;
  int m_arob, m_aop;

  function automatic logic [32:0] res(input bit p, input int t, input logic [31:0] v);
    if (!p) return {1'b0, v};
    if (cav && int'(cat) == t) return {1'b0, caval};
    if (clv && int'(clt) == t) return {1'b0, clval};
    return {1'b1, v};
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    int iss, fr;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_pj[i] = 0; m_pk[i] = 0; end
      m_av = 0; m_r1 = 0; m_r2 = 0; m_arob = 0; m_aop = 0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        m_av = 0;
      end else begin
        iss = -1;
        fr = -1;
        for (int i = 0; i < N; i++) begin
          if (iss < 0 && m_busy[i] && !m_pj[i] && !m_pk[i]) iss = i;
          if (fr < 0 && !m_busy[i]) fr = i;
        end
        m_av = (iss >= 0);
        if (iss >= 0) begin
          m_r1 = m_vj[iss]; m_r2 = m_vk[iss]; m_arob = m_rob[iss]; m_aop = m_op[iss];
          m_busy[iss] = 0;
        end
        for (int i = 0; i < N; i++)
          if (m_busy[i]) begin
            {m_pj[i], m_vj[i]} = res(m_pj[i], m_tj[i], m_vj[i]);
            {m_pk[i], m_vk[i]} = res(m_pk[i], m_tk[i], m_vk[i]);
          end
        if (dv && fr >= 0) begin
          m_busy[fr] = 1; m_op[fr] = int'(dop); m_rob[fr] = int'(drob);
          m_tj[fr] = int'(dqj); m_tk[fr] = int'(dqk);
          {m_pj[fr], m_vj[fr]} = res(djb, int'(dqj), dvj);
          {m_pk[fr], m_vk[fr]} = res(dkb, int'(dqk), dvk);
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk) begin
      cmp("full", {31'b0, full}, {31'b0, m_full()});
      cmp("alu_valid", {31'b0, av}, {31'b0, m_av});
      cmp("alu_r1", ar1, m_r1);
      cmp("alu_r2", ar2, m_r2);
      cmp("alu_rob_idx", {28'b0, arob}, m_arob);
      cmp("alu_op", {27'b0, aop}, m_aop);
    end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    dv = 0; djb = 0; dkb = 0; dop = '0; drob = '0; dqj = '0; dqk = '0; dvj = '0; dvk = '0;
    cav = 0; cat = '0; caval = '0; clv = 0; clt = '0; clval = '0; flush = 0; rdy = 1;
  endtask

  task automatic dis(input int rob, input logic [31:0] vj, input logic [31:0] vk,
                     input bit jb, input int tj);
    dv = 1; dop = RS_TYPE_BIT'(OP_ADD); drob = ROB_SIZE_BIT'(rob); dvj = vj; dvk = vk;
    djb = jb; dqj = ROB_SIZE_BIT'(tj); dkb = 0; dqk = '0;
  endtask

  task automatic lit(input string nm, input bit v, input int rob, input logic [31:0] r1,
                     input bit f);
    cmp({nm, "_valid"}, {31'b0, av}, {31'b0, v});
    if (v) begin
      cmp({nm, "_rob"}, {28'b0, arob}, rob);
      cmp({nm, "_r1"}, ar1, r1);
    end
    cmp({nm, "_full"}, {31'b0, full}, {31'b0, f});
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk = 1;
    cmp("rst_r2", ar2, 32'h0);
    cmp("rst_op", {27'b0, aop}, 32'h0);
    lit("rst", 0, 0, 0, 0);
    cmp("rst_r1", ar1, 32'h0);
    // single ready ADD issues one edge after dispatch
    dis(3, 5, 7, 0, 0); tick();
    idle(); tick();
    lit("add", 1, 3, 5, 0);
    cmp("add_r2", ar2, 32'h7);
    cmp("model_add_r2", m_r2, 32'h7);
    tick();
    lit("add_done", 0, 0, 0, 0);
    // pending operand woken by ALU CDB two cycles later
    dis(1, 0, 1, 1, 4); tick();
    idle(); tick();
    cav = 1; cat = 4; caval = 32'h10; tick();
    idle();
    lit("wake_wait", 0, 0, 0, 0);
    tick();
    lit("wake", 1, 1, 32'h10, 0);
    // capture at dispatch from same-cycle LSB CDB
    dis(2, 0, 0, 1, 6); clv = 1; clt = 6; clval = 9; tick();
    idle(); tick();
    lit("dcap", 1, 2, 9, 0);
    // fill all slots, drop the ninth, then free slot 2
    for (int i = 0; i < N; i++) begin dis(i, 0, 0, 1, 8 + i); tick(); end
    lit("fill", 0, 0, 0, 1);
    dis(9, 32'h99, 0, 0, 0); tick();
    lit("drop", 0, 0, 0, 1);
    idle(); cav = 1; cat = 10; caval = 32'h22; tick();
    idle(); tick();
    lit("slot2", 1, 2, 32'h22, 0);
    dis(12, 32'h55, 0, 0, 0); tick();
    idle();
    lit("refill", 0, 0, 0, 1);
    tick();
    lit("refill_iss", 1, 12, 32'h55, 0);
    flush = 1; tick(); idle();
    lit("flush_a", 0, 0, 0, 0);
    // two entries ready together: lower index first
    for (int i = 0; i < 6; i++) begin dis(i, 0, 0, 1, i + 1); tick(); end
    idle(); cav = 1; cat = 2; caval = 32'h11; clv = 1; clt = 6; clval = 32'h55; tick();
    idle(); tick();
    lit("prio1", 1, 1, 32'h11, 0);
    tick();
    lit("prio5", 1, 5, 32'h55, 0);
    tick();
    lit("prio_end", 0, 0, 0, 0);
    flush = 1; tick(); idle();
    // flush while 4 entries are busy and an issue is in flight
    for (int i = 0; i < 4; i++) begin dis(i, 0, 0, 1, 15); tick(); end
    dis(7, 32'h77, 0, 0, 0); tick();
    idle(); tick();
    lit("pre_flush", 1, 7, 32'h77, 0);
    flush = 1; dis(9, 1, 1, 0, 0); tick();
    idle();
    lit("flush_b", 0, 0, 0, 0);
    tick();
    lit("flush_c", 0, 0, 0, 0);
    // freeze for 3 cycles while traffic is presented
    dis(5, 32'hAB, 0, 0, 0); tick();
    dis(6, 32'hCD, 0, 0, 0); tick();
    lit("frz_pre", 1, 5, 32'hAB, 0);
    rdy = 0; dis(1, 3, 3, 0, 0); cav = 1; cat = 0; caval = 1;
    for (int i = 0; i < 3; i++) begin tick(); lit("frz", 1, 5, 32'hAB, 0); end
    idle(); tick();
    lit("resume", 1, 6, 32'hCD, 0);
    tick();
    lit("resume_end", 0, 0, 0, 0);
    // random traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      dv = ($urandom_range(0, 9) < 6);
      dop = RS_TYPE_BIT'($urandom_range(0, 19));
      drob = ROB_SIZE_BIT'($urandom);
      dvj = $urandom; dvk = $urandom;
      djb = $urandom_range(0, 1) == 1; dkb = $urandom_range(0, 2) == 0;
      dqj = ROB_SIZE_BIT'($urandom); dqk = ROB_SIZE_BIT'($urandom);
      cav = $urandom_range(0, 1) == 1; cat = ROB_SIZE_BIT'($urandom); caval = $urandom;
      clv = $urandom_range(0, 1) == 1; clt = ROB_SIZE_BIT'($urandom); clval = $urandom;
      if ($urandom_range(0, 3) == 0) clt = cat;
      flush = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      rst = (c == 1500);
      tick();
    end
    rst = 0; idle(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
